// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined adder: slice geometry and saturation patterns.
package pipe_adder_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    // Nominal chunk width: ceil(width / stages).
    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return (width + stages - 1) / stages;
    endfunction

    // Lowest operand bit handled by slice k.
    function automatic int unsigned chunk_lo(input int unsigned k, input int unsigned cw);
        return k * cw;
    endfunction

    // Actual bit count of slice k; the last chunks may be narrower or empty.
    function automatic int unsigned chunk_len(input int unsigned k, input int unsigned cw,
                                              input int unsigned width);
        int unsigned lo;
        int unsigned hi;
        lo = k * cw;
        hi = (k + 1) * cw;
        if (hi > width) hi = width;
        return (hi > lo) ? hi - lo : 0;
    endfunction

    // Largest positive two's-complement value of the given width (0111..1).
    function automatic logic [MAX_WIDTH-1:0] sat_max_pos(input int unsigned width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

    // Most negative two's-complement value of the given width (1000..0).
    function automatic logic [MAX_WIDTH-1:0] sat_min_neg(input int unsigned width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered chunk of the carry chain: sum and carry-out captured when en is high.
module adder_slice #(
    parameter int unsigned CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    localparam int unsigned SW = CW + 1;

    logic [CW-1:0] sum_d;
    logic [CW-1:0] sum_q;
    logic          cout_d;
    logic          cout_q;

    // Chunk addition; holds the previous result while the pipeline is stalled.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        if (en) begin
            {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + SW'(cin);
        end
    end

    // Slice result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor with valid/ready on both sides.
// The carry chain is cut into STAGES registered slices; operands are skewed
// into the slices and partial sums deskewed so a whole result emerges at once.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2,
    parameter int unsigned SAT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned      CW      = chunk_w(WIDTH, STAGES);
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_max_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_min_neg(WIDTH));

    logic                    advance_c;
    logic [WIDTH-1:0]        b_eff_c;
    logic [STAGES-1:0]       valid_d;
    logic [STAGES-1:0]       valid_q;
    // Per stage: {sign of A, sign of effective B}, needed for flags at the output.
    logic [STAGES-1:0][1:0]  sgn_d;
    logic [STAGES-1:0][1:0]  sgn_q;
    logic [STAGES-1:0]       slice_cout;
    logic [WIDTH-1:0]        sum_raw_c;
    logic                    cout_c;
    logic                    msb_cin_c;
    logic                    ovf_c;

    assign advance_c = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = advance_c;
    assign out_valid = valid_q[STAGES-1];
    assign b_eff_c   = sub ? ~b : b;

    // Valid bits and operand signs shift together with the data on advance.
    always_comb begin
        valid_d = valid_q;
        sgn_d   = sgn_q;
        if (advance_c) begin
            valid_d[0] = in_valid;
            sgn_d[0]   = {a[WIDTH-1], b_eff_c[WIDTH-1]};
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                sgn_d[i]   = sgn_q[i-1];
            end
        end
    end

    // Valid chain and sign pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            sgn_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sgn_q   <= sgn_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int unsigned LO  = chunk_lo(k, CW);
        localparam int unsigned LEN = chunk_len(k, CW, WIDTH);
        localparam int unsigned DSK = STAGES - 1 - k;

        logic cin_c;

        if (k == 0) begin : g_cin_first
            assign cin_c = sub;
        end else begin : g_cin_chain
            assign cin_c = slice_cout[k-1];
        end

        if (LEN == 0) begin : g_empty
            // No operand bits left for this slice: the carry simply rides one more register.
            logic carry_d;
            logic carry_q;

            // Pass-through carry, held on stall.
            always_comb begin
                carry_d = carry_q;
                if (advance_c) carry_d = cin_c;
            end

            // Pass-through carry register.
            always_ff @(posedge clk) begin
                if (rst) carry_q <= 1'b0;
                else     carry_q <= carry_d;
            end

            assign slice_cout[k] = carry_q;
        end else begin : g_live
            logic [LEN-1:0] op_a_c;
            logic [LEN-1:0] op_b_c;
            logic [LEN-1:0] part_sum;

            if (k == 0) begin : g_no_skew
                assign op_a_c = a[LO +: LEN];
                assign op_b_c = b_eff_c[LO +: LEN];
            end else begin : g_skew
                logic [k-1:0][LEN-1:0] a_dly_d;
                logic [k-1:0][LEN-1:0] a_dly_q;
                logic [k-1:0][LEN-1:0] b_dly_d;
                logic [k-1:0][LEN-1:0] b_dly_q;

                // Delay this slice's operand bits by k cycles so they meet their carry.
                always_comb begin
                    a_dly_d = a_dly_q;
                    b_dly_d = b_dly_q;
                    if (advance_c) begin
                        a_dly_d[0] = a[LO +: LEN];
                        b_dly_d[0] = b_eff_c[LO +: LEN];
                        for (int i = 1; i < k; i++) begin
                            a_dly_d[i] = a_dly_q[i-1];
                            b_dly_d[i] = b_dly_q[i-1];
                        end
                    end
                end

                // Operand skew registers.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_dly_q <= '0;
                        b_dly_q <= '0;
                    end else begin
                        a_dly_q <= a_dly_d;
                        b_dly_q <= b_dly_d;
                    end
                end

                assign op_a_c = a_dly_q[k-1];
                assign op_b_c = b_dly_q[k-1];
            end

            adder_slice #(
                .CW(LEN)
            ) u_slice (
                .clk  (clk),
                .rst  (rst),
                .en   (advance_c),
                .a    (op_a_c),
                .b    (op_b_c),
                .cin  (cin_c),
                .sum  (part_sum),
                .cout (slice_cout[k])
            );

            if (DSK == 0) begin : g_no_deskew
                assign sum_raw_c[LO +: LEN] = part_sum;
            end else begin : g_deskew
                logic [DSK-1:0][LEN-1:0] dsk_d;
                logic [DSK-1:0][LEN-1:0] dsk_q;

                // Hold early partial sums until the top slice has finished.
                always_comb begin
                    dsk_d = dsk_q;
                    if (advance_c) begin
                        dsk_d[0] = part_sum;
                        for (int i = 1; i < DSK; i++) begin
                            dsk_d[i] = dsk_q[i-1];
                        end
                    end
                end

                // Sum deskew registers.
                always_ff @(posedge clk) begin
                    if (rst) dsk_q <= '0;
                    else     dsk_q <= dsk_d;
                end

                assign sum_raw_c[LO +: LEN] = dsk_q[DSK-1];
            end
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and the operand signs.
    assign cout_c    = slice_cout[STAGES-1];
    assign msb_cin_c = sum_raw_c[WIDTH-1] ^ sgn_q[STAGES-1][1] ^ sgn_q[STAGES-1][0];
    assign ovf_c     = cout_c ^ msb_cin_c;

    // Optional clamp to the signed range, direction chosen by A's sign.
    always_comb begin
        sum = sum_raw_c;
        if ((SAT != 0) && ovf_c) begin
            sum = sgn_q[STAGES-1][1] ? SAT_NEG : SAT_POS;
        end
    end

    assign cout = cout_c;
    assign ovf  = ovf_c;

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output. It generalises the team's fixed 6-bit combinational adder to any width. The carry chain is split into `STAGES` registered slices, which gives one result per cycle at a higher clock rate. It adds subtract mode, carry/borrow and signed-overflow flags, and optional signed saturation. It sits between operand producers and result consumers in the datapath, and either side may stall.

## Interface
- `WIDTH`, 6: operand and result width in bits, ≥ 2.
- `STAGES`, 2: number of pipeline slices, 1 ≤ `STAGES` ≤ `WIDTH`.
- `SAT`, 0: 0 = wrap-around result; 1 = signed saturation on overflow.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operands `a`, `b`, `sub` are valid.
- `in_ready` out 1: the block accepts operands this cycle.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B.
- `sub` in 1: 0 = A+B; 1 = A−B.
- `out_valid` out 1: `sum`, `cout`, `ovf` are valid.
- `out_ready` in 1: the consumer accepts the result this cycle.
- `sum` out `WIDTH`: result (wrapped, or saturated when `SAT`=1).
- `cout` out 1: carry out of the MSB. For `sub`, 1 means no borrow (A ≥ B unsigned).
- `ovf` out 1: signed overflow of the unsaturated result.

## Operation
- **Operation:** `sub`=1 computes A + ~B + 1, with carry-in 1 into slice 0. `sub`=0 computes A + B, with carry-in 0.
- **Slicing:**
  - Chunk width CW = ceil(`WIDTH`/`STAGES`).
  - Slice k adds bits [k·CW, min((k+1)·CW, `WIDTH`)−1] plus the registered carry from slice k−1.
  - The last chunk may be narrower.
- **Operand skew:**
  - Operand bits for upper slices are delayed k cycles so they meet their carry.
  - Sum bits of lower slices are delayed so that all bits of one result emerge together.
- **Flags:**
  - `cout` is the carry out of bit `WIDTH`−1.
  - `ovf` = carry into MSB XOR carry out of MSB.
- **Saturation** (`SAT`=1 and `ovf`=1):
  - `sum` = 0 followed by all 1s (max positive) if A's sign bit is 0.
  - Otherwise `sum` = 1 followed by all 0s (min negative).
  - A's sign is carried through the pipeline for this decision.
  - `ovf` still reports 1.
- **Pipeline control:**
  - Each stage holds a valid bit.
  - Global advance = !out_valid || out_ready.
  - `in_ready` = advance.
  - On advance, every stage shifts one position. A transfer into stage 0 occurs iff in_valid && in_ready.
  - When not advancing, all stage registers hold.
- **Ordering:** results emerge in acceptance order. No result is dropped or duplicated.
- **Reset:**
  - `rst` clears all stage valid bits, so `out_valid`=0 and `in_ready`=1 in the following cycle.
  - `sum`, `cout`, `ovf` read 0.
  - Reset mid-operation discards all in-flight operations, with no partial outputs.
  - `rst` has priority over any simultaneous handshake.

## Timing
- **Latency:** exactly `STAGES` cycles from the accepting edge to `out_valid`=1, with no stall.
- **Throughput:** one operation per cycle while `out_ready`=1.
- **Stall:**
  - When `out_valid`=1 and `out_ready`=0, `in_ready`=0 in the same cycle (combinational).
  - `sum`/`cout`/`ovf` stay stable until accepted.
- **Simultaneous events:** `out_ready`=1 with `in_valid`=1 on a full pipeline accepts a new operand and retires the head result on the same edge.
- **Empty bubbles:** bubbles propagate with valid=0. `out_valid` deasserts in the cycle after the last result is accepted, unless a new result arrives behind it.
- **Degenerate pipeline:** `STAGES`=1 is a single register stage, with latency 1.

## Structure
- **Package `pipe_adder_pkg`:**
  - function `chunk_w(WIDTH, STAGES)`;
  - function `chunk_lo(k)`;
  - constants for saturation patterns, generated from `WIDTH`.
- **Sub-module `adder_slice`:**
  - Parametrised chunk width.
  - Registered chunk sum and carry-out, with an enable tied to advance.
- **Top level:**
  - generate-instantiates `STAGES` slices;
  - skew/deskew shift registers;
  - valid chain;
  - flag and saturation logic.

## Test plan
All scenarios use `WIDTH`=6.
- **Add, `STAGES`=2, `SAT`=0:**
  - 000101+000011 gives `sum`=001000, `cout`=0, `ovf`=0, valid exactly 2 cycles after acceptance.
  - 111101+111110 gives 111011, `cout`=1, `ovf`=0.
- **Signed overflow, wrap vs saturate:**
  - 011111+000001 with `SAT`=0 gives `sum`=100000, `ovf`=1.
  - The same operands with `SAT`=1 give `sum`=011111, `ovf`=1.
  - 100000+111111 with `SAT`=1 gives 100000, `ovf`=1.
- **Subtract:**
  - 000101−000111 gives 111110, `cout`=0, `ovf`=0.
  - 001011−000010 gives 001001, `cout`=1.
- **Backpressure:**
  - Stream 6 back-to-back operands, holding `out_ready`=0 for 3 cycles mid-stream.
  - `in_ready` drops in the same cycle and results hold stable.
  - All 6 results arrive in order with no loss.
- **Reset mid-stream:** pulse `rst` with 2 operations in flight. The next cycle shows `out_valid`=0 and `sum`=0, and neither operation's result ever appears.
- **Sweep:** `STAGES` ∈ {1, 4, 6} over random operands, checked against the reference A±B mod 2^6 and its flags, including full-throughput and random-stall patterns.
